kf8237_transfer_sequencer: RTL and testbench

KF8237_TRANSFER_SEQUENCER -- requirements
Module: kf8237_transfer_sequencer

---
 rtl/kf8237_transfer_sequencer_if.sv | 28 ++
 rtl/kf8237_transfer_sequencer.sv | 142 ++++++++++++++
 tb/tb_kf8237_transfer_sequencer.sv | 307 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/kf8237_transfer_sequencer_if.sv
// DMA bus bundle: DREQ/HLDA inputs plus HRQ, DACK, AEN, ADSTB, strobes.
// master = sequencer side, slave = CPU/peripheral side.
interface kf8237_transfer_sequencer_if;
  logic [3:0] dma_request;
  logic       hlda;
  logic       hrq;
  logic [3:0] dack;
  logic       aen;
  logic       adstb;
  logic       mem_read;
  logic       mem_write;
  logic       io_read;
  logic       io_write;

  modport master (
    input  dma_request, hlda,
    output hrq, dack, aen, adstb,
    output mem_read, mem_write,
    output io_read, io_write
  );

  modport slave (
    output dma_request, hlda,
    input  hrq, dack, aen, adstb,
    input  mem_read, mem_write,
    input  io_read, io_write
  );
endinterface

// File: rtl/kf8237_transfer_sequencer.sv
// 8237 transfer sequencer: SI/S0..S4 FSM, channel arbitration, TC/EOP pulses.
// Ports: clock/reset, DMA clock strobes, bus (if), command bits, mode/type/autoinit, TC.
module kf8237_transfer_sequencer (
  input  logic       clock,
  input  logic       reset,
  input  logic       cpu_clock_posedge,
  input  logic       cpu_clock_negedge,
  kf8237_transfer_sequencer_if.master bus,
  input  logic [3:0] mask,
  input  logic       controller_disable,
  input  logic       rotating_priority,
  input  logic       dreq_sense_low,
  input  logic       dack_sense_high,
  input  logic [7:0] transfer_mode,
  input  logic [7:0] transfer_type,
  input  logic [3:0] autoinit,
  input  logic       underflow,
  input  logic       update_high_address,
  input  logic       clear_terminal_count,
  output logic [3:0] transfer_register_select,
  output logic       next_word,
  output logic       initialize_current_register,
  output logic       end_of_process,
  output logic [3:0] set_mask_by_tc,
  output logic [3:0] terminal_count
);

  typedef enum logic [2:0] {SI, S0, S1, S2, S3, S4} state_t;

  state_t     state, state_next;
  logic [1:0] sel, sel_next;
  logic [1:0] top, top_next;
  logic [3:0] dreq_act;
  logic [3:0] active;
  logic [3:0] onehot;
  logic [1:0] base, winner, c;
  logic       any;
  logic       eop_set;
  logic [1:0] mode, ty;
  logic       xfer, wr;
  logic [3:0] dack_act;

  // DREQ is sampled on the DMA clock falling edge, normalised to active-high
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= SI;
      sel      <= 2'd0;
      top      <= 2'd0;
      dreq_act <= 4'b0;
      end_of_process              <= 1'b0;
      initialize_current_register <= 1'b0;
      set_mask_by_tc              <= 4'b0;
      terminal_count              <= 4'b0;
    end else begin
      if (cpu_clock_negedge)
        dreq_act <= dreq_sense_low ? ~bus.dma_request
                                   : bus.dma_request;
      state <= state_next;
      sel   <= sel_next;
      top   <= top_next;
      end_of_process <= eop_set;
      initialize_current_register <= eop_set & autoinit[sel];
      set_mask_by_tc <= (eop_set & ~autoinit[sel]) ? onehot
                                                   : 4'b0;
      // a set wins over a simultaneous clear
      terminal_count <=
        (clear_terminal_count ? 4'b0 : terminal_count) |
        (eop_set ? onehot : 4'b0);
    end
  end

  assign active = dreq_act & ~mask & {4{~controller_disable}};
  assign base   = rotating_priority ? top : 2'd0;
  assign onehot = 4'b0001 << sel;
  assign mode   = transfer_mode[{sel, 1'b0} +: 2];
  assign ty     = transfer_type[{sel, 1'b0} +: 2];

  always_comb begin
    any    = 1'b0;
    winner = 2'd0;
    c      = 2'd0;
    for (int i = 0; i < 4; i++) begin
      c = base + i[1:0];
      if (!any && active[c]) begin
        winner = c;
        any    = 1'b1;
      end
    end
  end

  always_comb begin
    state_next = state;
    sel_next   = sel;
    top_next   = top;
    eop_set    = 1'b0;
    if (cpu_clock_posedge) begin
      unique case (state)
        SI: if (any) begin
          state_next = S0;
          sel_next   = winner;
        end
        S0: if (bus.hlda) state_next = S1;
        S1: state_next = bus.hlda ? S2 : SI;
        S2: state_next = bus.hlda ? S3 : SI;
        S3: state_next = bus.hlda ? S4 : SI;
        S4: begin
          if (!bus.hlda) begin
            state_next = SI;
          end else begin
            state_next = SI;
            if (underflow) begin
              eop_set = 1'b1;
            end else if (mode == 2'b10 ||
                        (mode == 2'b00 && dreq_act[sel])) begin
              state_next = update_high_address ? S1 : S2;
            end
            // completed service: serviced channel drops to lowest
            if (state_next == SI && rotating_priority)
              top_next = sel + 2'd1;
          end
        end
        default: state_next = SI;
      endcase
    end
  end

  assign xfer = (state == S2) || (state == S3) || (state == S4);
  assign wr   = (state == S3) || (state == S4);
  assign dack_act = xfer ? onehot : 4'b0;

  assign bus.hrq       = (state != SI);
  assign bus.aen       = (state != SI) && (state != S0);
  assign bus.adstb     = (state == S1);
  assign bus.dack      = dack_sense_high ? dack_act : ~dack_act;
  assign bus.mem_read  = xfer && (ty == 2'b10);
  assign bus.io_read   = xfer && (ty == 2'b01);
  assign bus.mem_write = wr && (ty == 2'b01);
  assign bus.io_write  = wr && (ty == 2'b10);
  assign next_word     = (state == S4) && bus.hlda;
  assign transfer_register_select = bus.hrq ? onehot : 4'b0;

endmodule

// File: tb/tb_kf8237_transfer_sequencer.sv
// Bench for kf8237_transfer_sequencer: directed and random transfers
// checked against a transaction-level model of the bus cycles.
module tb_kf8237_transfer_sequencer;
  logic       clock = 0;
  logic       reset;
  logic       cpu_clock_posedge, cpu_clock_negedge;
  logic [3:0] mask;
  logic       controller_disable, rotating_priority;
  logic       dreq_sense_low, dack_sense_high;
  logic [7:0] transfer_mode, transfer_type;
  logic [3:0] autoinit;
  logic       underflow, update_high_address;
  logic       clear_terminal_count;
  logic [3:0] transfer_register_select;
  logic       next_word, initialize_current_register;
  logic       end_of_process;
  logic [3:0] set_mask_by_tc, terminal_count;

  int errors = 0;
  int checks = 0;
  logic [3:0] tc_m;
  int prio[$];

  kf8237_transfer_sequencer_if bus ();

  kf8237_transfer_sequencer dut (
    .clock(clock),
    .reset(reset),
    .cpu_clock_posedge(cpu_clock_posedge),
    .cpu_clock_negedge(cpu_clock_negedge),
    .bus(bus),
    .mask(mask),
    .controller_disable(controller_disable),
    .rotating_priority(rotating_priority),
    .dreq_sense_low(dreq_sense_low),
    .dack_sense_high(dack_sense_high),
    .transfer_mode(transfer_mode),
    .transfer_type(transfer_type),
    .autoinit(autoinit),
    .underflow(underflow),
    .update_high_address(update_high_address),
    .clear_terminal_count(clear_terminal_count),
    .transfer_register_select(transfer_register_select),
    .next_word(next_word),
    .initialize_current_register(initialize_current_register),
    .end_of_process(end_of_process),
    .set_mask_by_tc(set_mask_by_tc),
    .terminal_count(terminal_count)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] o,
                     input logic [31:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, o, e);
    end
  endtask

  // one DMA clock: falling strobe, then rising strobe
  task automatic step(input bit clr = 0);
    @(negedge clock);
    cpu_clock_negedge = 1;
    cpu_clock_posedge = 0;
    @(negedge clock);
    cpu_clock_negedge = 0;
    cpu_clock_posedge = 1;
    clear_terminal_count = clr;
    @(negedge clock);
    cpu_clock_posedge = 0;
    clear_terminal_count = 0;
  endtask

  function automatic logic [15:0] obs();
    return {bus.hrq, bus.aen, bus.adstb, bus.mem_read,
            bus.mem_write, bus.io_read, bus.io_write,
            next_word, bus.dack, transfer_register_select};
  endfunction

  function automatic logic [9:0] pulses();
    return {end_of_process, initialize_current_register,
            set_mask_by_tc, terminal_count};
  endfunction

  // ph: 0 idle, 1 hold request, 2 address, 3 read, 4 write, 5 last
  function automatic logic [15:0] exp_bus(input int ph,
                                          input int w,
                                          input int ty);
    logic [3:0] oh, dk;
    logic rd, wr;
    oh = 4'b0001 << w;
    rd = ph >= 3;
    wr = ph >= 4;
    dk = rd ? oh : 4'b0000;
    if (!dack_sense_high) dk = ~dk;
    return {ph >= 1, ph >= 2, ph == 2, rd && ty == 2,
            wr && ty == 1, rd && ty == 1, wr && ty == 2,
            ph == 5, dk, (ph >= 1) ? oh : 4'b0000};
  endfunction

  function automatic int pick(input logic [3:0] act);
    int order[4];
    int p;
    p = -1;
    for (int i = 0; i < 4; i++)
      order[i] = rotating_priority ? prio[i] : i;
    for (int i = 3; i >= 0; i--)
      if (act[order[i]]) p = order[i];
    return p;
  endfunction

  function automatic logic [3:0] drv(input logic [3:0] r);
    return dreq_sense_low ? ~r : r;
  endfunction

  task automatic xfer(input logic [3:0] req, input int nw,
                      input bit aut, input bit stop,
                      input bit clr);
    int w, md, ty, words;
    bit last, uf, uha, in_s1;
    logic [3:0] oh;
    w  = pick(req & ~mask);
    oh = 4'b0001 << w;
    md = int'(transfer_mode[2*w +: 2]);
    ty = int'(transfer_type[2*w +: 2]);
    autoinit[w] = aut;
    words = (md == 1 || md == 3) ? 1 : nw;
    if (md == 2) stop = 0;
    bus.dma_request = drv(req);
    bus.hlda = 0;
    step();
    chk("s0", obs(), exp_bus(1, w, ty));
    bus.hlda = 1;
    step();
    chk("s1", obs(), exp_bus(2, w, ty));
    in_s1 = 1;
    for (int k = 0; k < words; k++) begin
      last = (k == words - 1);
      if (in_s1) begin
        step();
        chk("s2", obs(), exp_bus(3, w, ty));
      end
      step();
      chk("s3", obs(), exp_bus(4, w, ty));
      step();
      chk("s4", obs(), exp_bus(5, w, ty));
      uf  = last && !stop;
      uha = 1'($urandom % 2);
      underflow = uf;
      update_high_address = uha;
      if (last && stop) bus.dma_request = drv(req & ~oh);
      step(last && clr);
      underflow = 0;
      update_high_address = 0;
      if (last) begin
        chk("end_idle", obs(), exp_bus(0, w, ty));
        tc_m = (clr ? 4'b0 : tc_m) | (uf ? oh : 4'b0);
        chk("end_pulse", pulses(),
            {uf, uf && aut, (uf && !aut) ? oh : 4'b0, tc_m});
        if (rotating_priority)
          while (prio[3] != w) prio.push_back(prio.pop_front());
        @(posedge clock);
        #1;
        chk("pulse_width", pulses(), {6'b0, tc_m});
      end else begin
        in_s1 = uha;
        chk("continue", obs(), exp_bus(uha ? 2 : 3, w, ty));
      end
    end
    bus.dma_request = drv(4'b0);
    bus.hlda = 0;
  endtask

  initial begin
    int ch, ty;
    logic [3:0] req;
    prio = '{0, 1, 2, 3};
    tc_m = 4'b0;
    reset = 1;
    cpu_clock_posedge = 0;
    cpu_clock_negedge = 0;
    mask = 0;
    controller_disable = 0;
    rotating_priority = 0;
    dreq_sense_low = 0;
    dack_sense_high = 0;
    transfer_mode = 0;
    transfer_type = 0;
    autoinit = 0;
    underflow = 0;
    update_high_address = 0;
    clear_terminal_count = 0;
    bus.dma_request = 0;
    bus.hlda = 0;
    repeat (3) @(negedge clock);
    chk("reset_bus", obs(), exp_bus(0, 0, 0));
    chk("reset_pulse", pulses(), 10'b0);
    reset = 0;

    // single read on ch1, count nonzero
    transfer_mode = 8'b00_00_01_00;
    transfer_type = 8'b00_00_10_00;
    xfer(4'b0010, 1, 0, 1, 0);
    // block on ch0, TC at third word, without and with autoinit
    transfer_mode = 8'b00_00_00_10;
    transfer_type = 8'b00_00_00_01;
    xfer(4'b0001, 3, 0, 0, 0);
    xfer(4'b0001, 3, 1, 0, 0);
    // demand on ch2 ended by DREQ dropping
    dack_sense_high = 1;
    dreq_sense_low = 1;
    transfer_mode = 8'b00_00_00_00;
    transfer_type = 8'b00_10_00_00;
    xfer(4'b0100, 2, 0, 1, 0);

    // masked and disabled requests are ignored
    mask = 4'b1111;
    bus.dma_request = drv(4'b1111);
    step();
    chk("masked", obs(), exp_bus(0, 0, 0));
    mask = 4'b0000;
    controller_disable = 1;
    step();
    chk("disabled", obs(), exp_bus(0, 0, 0));
    controller_disable = 0;
    bus.dma_request = drv(4'b0);

    for (int n = 0; n < 12; n++) begin
      dack_sense_high = 1'($urandom % 2);
      dreq_sense_low  = 1'($urandom % 2);
      transfer_mode   = 8'($urandom);
      transfer_type   = 8'($urandom);
      ch   = int'($urandom % 4);
      mask = 4'($urandom) & ~(4'b0001 << ch);
      req  = 4'($urandom) | (4'b0001 << ch);
      xfer(req, 1 + int'($urandom % 3), 1'($urandom % 2),
           1'($urandom % 2), 1'($urandom % 2));
    end
    mask = 0;

    // rotating priority: winners follow the model's list
    rotating_priority = 1;
    transfer_mode = 8'h55;
    repeat (3) xfer(4'b0101, 1, 0, 1, 0);
    repeat (3) xfer(4'b1110, 1, 0, 1, 0);
    rotating_priority = 0;

    // TC set, then explicit clear
    transfer_mode = 8'b10_10_10_10;
    xfer(4'b0010, 1, 0, 0, 0);
    @(negedge clock);
    clear_terminal_count = 1;
    @(negedge clock);
    clear_terminal_count = 0;
    tc_m = 4'b0;
    chk("tc_clear", terminal_count, tc_m);
    // set on ch1 then set ch2 with a coincident clear
    xfer(4'b0010, 1, 0, 0, 0);
    xfer(4'b0100, 2, 0, 0, 1);

    // hlda dropped in S3 aborts without next_word or TC
    ty = int'(transfer_type[7:6]);
    bus.dma_request = drv(4'b1000);
    step();
    chk("abort_s0", obs(), exp_bus(1, 3, ty));
    bus.hlda = 1;
    step();
    step();
    step();
    chk("abort_s3", obs(), exp_bus(4, 3, ty));
    bus.hlda = 0;
    underflow = 1;
    step();
    underflow = 0;
    chk("abort_idle", obs(), exp_bus(0, 3, ty));
    chk("abort_tc", pulses(), {6'b0, tc_m});
    bus.dma_request = drv(4'b0);

    // reset in S4 clears everything at once
    ty = int'(transfer_type[3:2]);
    bus.dma_request = drv(4'b0010);
    step();
    bus.hlda = 1;
    repeat (4) step();
    chk("pre_reset_s4", obs(), exp_bus(5, 1, ty));
    underflow = 1;
    reset = 1;
    #1;
    chk("mid_reset_bus", obs(), exp_bus(0, 1, ty));
    chk("mid_reset_pulse", pulses(), 10'b0);
    tc_m = 4'b0;
    prio = '{0, 1, 2, 3};
    @(negedge clock);
    underflow = 0;
    bus.hlda = 0;
    bus.dma_request = drv(4'b0);
    reset = 0;
    step();
    chk("post_reset", obs(), exp_bus(0, 1, ty));
    chk("post_reset_pulse", pulses(), 10'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
